seg7_scan_driver: RTL and testbench

Time-multiplexed 8-digit seven-segment scan driver. It sits directly downstream of the register file and consumes the 32-bit `{S, R}` read-port word, showing eight hex nibbles on a common-anode display. It snapshots the input word once per scan frame, so a display frame never mixes old and new values. It also inserts anode dead-time between digits to suppress ghosting.

---
 rtl/seg7_scan_driver_pkg.sv | 11 +
 rtl/hex_to_7seg.sv | 33 +++
 rtl/seg7_defs.vh | 25 ++
 rtl/seg7_scan_driver.sv | 99 +++++++++
 tb/tb_seg7_scan_driver.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// rtl/seg7_scan_driver_pkg.sv - shared constants and helpers for the seven-segment scan driver
package seg7_scan_driver_pkg;

  `include "seg7_defs.vh"

  // Active-low one-cold anode pattern selecting a single digit.
  function automatic logic [7:0] anode_sel(input logic [2:0] digit);
    return ~(8'h01 << digit);
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational hex nibble to active-low seven-segment decoder
module hex_to_7seg
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup; segment order is {g,f,e,d,c,b,a}.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_defs.vh
// rtl/seg7_defs.vh - shared seven-segment constants (active-low segments, anodes)
`ifndef SEG7_DEFS_VH
`define SEG7_DEFS_VH

localparam logic [6:0] SEG_HEX_0 = 7'h40;
localparam logic [6:0] SEG_HEX_1 = 7'h79;
localparam logic [6:0] SEG_HEX_2 = 7'h24;
localparam logic [6:0] SEG_HEX_3 = 7'h30;
localparam logic [6:0] SEG_HEX_4 = 7'h19;
localparam logic [6:0] SEG_HEX_5 = 7'h12;
localparam logic [6:0] SEG_HEX_6 = 7'h02;
localparam logic [6:0] SEG_HEX_7 = 7'h78;
localparam logic [6:0] SEG_HEX_8 = 7'h00;
localparam logic [6:0] SEG_HEX_9 = 7'h10;
localparam logic [6:0] SEG_HEX_A = 7'h08;
localparam logic [6:0] SEG_HEX_B = 7'h03;
localparam logic [6:0] SEG_HEX_C = 7'h46;
localparam logic [6:0] SEG_HEX_D = 7'h21;
localparam logic [6:0] SEG_HEX_E = 7'h06;
localparam logic [6:0] SEG_HEX_F = 7'h0E;

localparam logic [6:0] SEG_BLANK = 7'h7F;
localparam logic [7:0] AN_OFF    = 8'hFF;

`endif

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit time-multiplexed seven-segment scan driver with frame snapshot
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seg_in,
  input  logic [7:0]  blank,
  input  logic [7:0]  dp_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYC);

  logic [CW-1:0] cnt;
  logic [2:0]    dig;
  logic [31:0]   snap_seg;
  logic [7:0]    snap_blank;
  logic [7:0]    snap_dp;

  logic          slot_end;
  logic          frame_start;
  logic          dark;
  logic [6:0]    dec_seg;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign slot_end    = (cnt == CNT_LAST);
  assign frame_start = (cnt == '0) && (dig == 3'd0);

  hex_to_7seg u_dec (
    .nibble (snap_seg[{dig, 2'b00} +: 4]),
    .seg    (dec_seg)
  );

  // Slot counter and digit index; the digit advances when the slot wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      dig <= 3'd0;
    end else if (slot_end) begin
      cnt <= '0;
      dig <= dig + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Snapshot inputs only at frame start so a frame never mixes old and new data.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_seg   <= '0;
      snap_blank <= '0;
      snap_dp    <= '0;
    end else if (frame_start) begin
      snap_seg   <= seg_in;
      snap_blank <= blank;
      snap_dp    <= dp_in;
    end
  end

  // Next output pattern: dark during dead-time or for blanked digits, else the decoded nibble.
  always_comb begin
    dark     = (cnt < DEAD_END) || snap_blank[dig];
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if (!dark) begin
      an_next  = anode_sel(dig);
      seg_next = dec_seg;
      dp_next  = ~snap_dp[dig];
    end
  end

  // Registered outputs; frame_done marks the last cycle of digit 7's slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      frame_done <= slot_end && (dig == 3'd7);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver against a frame-level model
module tb_seg7_scan_driver;

  localparam int RD    = 8;
  localparam int DC    = 2;
  localparam int FRAME = 8 * RD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] seg_in = '0;
  logic [7:0]  blank = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  int e = 0;
  int last = -1;

  logic [31:0] m_seg = '0;
  logic [7:0]  m_blank = '0;
  logic [7:0]  m_dp = '0;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(.REFRESH_DIV(RD), .DEAD_CYC(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .seg_in     (seg_in),
    .blank      (blank),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, last);
    end
  endtask

  // One clock edge: model computes what the display should show after it, then compare.
  task automatic tick();
    logic [7:0] ea;
    logic [6:0] es;
    logic       ed;
    logic       ef;
    int p, slot, off;
    @(posedge clk);
    if (reset) begin
      ea = 8'hFF; es = 7'h7F; ed = 1'b1; ef = 1'b0;
      e = 0;
      last = -1;
    end else begin
      p = e % FRAME;
      if (p == 0) begin
        m_seg = seg_in; m_blank = blank; m_dp = dp_in;
      end
      slot = p / RD;
      off  = p % RD;
      if (off < DC || m_blank[slot]) begin
        ea = 8'hFF; es = 7'h7F; ed = 1'b1;
      end else begin
        ea = 8'hFF;
        ea[slot] = 1'b0;
        es = dec_tab[(m_seg >> (4 * slot)) & 32'hF];
        ed = ~m_dp[slot];
      end
      ef = (p == FRAME - 1);
      last = e;
      e++;
    end
    #1;
    chk("an", an, ea);
    chk("seg", seg, es);
    chk("dp", dp, ed);
    chk("frame_done", frame_done, ef);
    chk("an_one_cold", ($countones(~an) <= 1), 1);
    chk("dark_seg", (an != 8'hFF) || (seg == 7'h7F && dp == 1'b1), 1);
  endtask

  task automatic run_to(input int n);
    for (int k = 0; k < 100000 && last < n; k++) tick();
  endtask

  initial begin
    // Reset hold
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Full frame
    seg_in = 32'h0123ABCD; blank = 8'h00; dp_in = 8'h00;
    reset = 1'b0;
    run_to(2);
    chk("d0_seg", seg, 7'h21);
    chk("d0_an", an, 8'hFE);
    run_to(3 * RD + 2);
    chk("d3_seg", seg, 7'h08);
    chk("d3_an", an, 8'hF7);
    run_to(7 * RD + 2);
    chk("d7_seg", seg, 7'h40);
    chk("d7_an", an, 8'h7F);
    run_to(FRAME - 1);
    chk("fd_first", frame_done, 1);
    seg_in = 32'h11111111;
    run_to(2 * FRAME - 2);
    chk("fd_gap", frame_done, 0);
    run_to(2 * FRAME - 1);
    chk("fd_second", frame_done, 1);

    // Snapshot integrity
    run_to(2 * FRAME + 3 * RD + 3);
    seg_in = 32'h22222222;
    run_to(2 * FRAME + 4 * RD + 2);
    chk("snap_d4", seg, 7'h79);
    run_to(2 * FRAME + 7 * RD + 7);
    chk("snap_d7", seg, 7'h79);
    run_to(3 * FRAME + 2);
    chk("snap_next_d0", seg, 7'h24);

    // Blank and decimal point
    run_to(4 * FRAME - 1);
    blank = 8'h80; dp_in = 8'h01;
    run_to(4 * FRAME + 2);
    chk("dp_d0", dp, 0);
    chk("dp_d0_an", an, 8'hFE);
    run_to(4 * FRAME + RD + 2);
    chk("dp_d1", dp, 1);
    run_to(4 * FRAME + 7 * RD + 4);
    chk("blank_d7_an", an, 8'hFF);

    // Mid-scan reset during digit 5
    run_to(5 * FRAME + 5 * RD + 3);
    reset = 1'b1;
    tick();
    chk("rst_mid_an", an, 8'hFF);
    seg_in = 32'h00000009; blank = 8'h00; dp_in = 8'h00;
    reset = 1'b0;
    run_to(1);
    chk("rel_dark", an, 8'hFF);
    run_to(2);
    chk("rel_d0_an", an, 8'hFE);
    chk("rel_d0_seg", seg, 7'h10);

    // Anode invariant with random inputs over 10 frames
    for (int i = 0; i < 10 * FRAME; i++) begin
      seg_in = $urandom;
      blank  = 8'($urandom);
      dp_in  = 8'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
